// File: rtl/spi_operand_loader.sv
// SPI slave front-end: receives an operand pair, presents it to the adder over
// valid/ready, and shifts the captured sum/carry back out during the next frame.
module spi_operand_loader #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spi_sclk,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         op_valid,
  input  logic         op_ready,
  input  logic [N-1:0] res_sum,
  input  logic         res_cout,
  output logic         frame_err
);
  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0] FULL = CW'(2*N);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   rx_sr_q, rx_sr_d;
  logic [N-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;
  logic [N-1:0]     res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic [N:0]       tx_sr_q, tx_sr_d;
  logic             miso_q, miso_d;
  logic             err_q, err_d;
  logic             rej_q, rej_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_act, hs;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_act    = ~cs_s;
  assign hs        = op_valid_q & op_ready;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;

    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    tx_sr_d    = tx_sr_q;
    err_d      = 1'b0;
    rej_d      = rej_q;
    miso_d     = cs_act ? tx_sr_q[N] : 1'b0;

    if (sclk_fall && cs_act) tx_sr_d = {tx_sr_q[N-1:0], 1'b0};

    // A frame started while the operands were still pending reports at its end.
    if (cs_rise) begin
      if (rej_q) err_d = 1'b1;
      rej_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Reloading only while deselected keeps a mid-frame capture out of MISO.
        if (!cs_act || cs_fall) tx_sr_d = {res_cout_q, res_sum_q};
        if (cs_fall) state_d = RECV;
      end
      RECV: begin
        if (cs_rise) begin
          if (cnt_q != '0) err_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise && cnt_q < FULL) begin
          rx_sr_d = {rx_sr_q[2*N-2:0], mosi_s};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == FULL - CW'(1)) begin
            op_a_d     = rx_sr_d[2*N-1:N];
            op_b_d     = rx_sr_d[N-1:0];
            op_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          res_sum_d  = res_sum;
          res_cout_d = res_cout;
          op_valid_d = 1'b0;
          if (cs_fall) begin
            // New frame in the handshake cycle returns the previous result.
            state_d = RECV;
            cnt_d   = '0;
            tx_sr_d = {res_cout_q, res_sum_q};
          end else begin
            state_d = IDLE;
          end
        end else if (cs_fall) begin
          rej_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      err_q       <= err_d;
      rej_q       <= rej_d;
    end
  end

  assign spi_miso  = miso_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_operand_loader.sv
// Scoreboard bench for spi_operand_loader: SPI master stimulus, frame-level reference
// model, and monitors comparing handshakes, frame_err pulses and MISO words.
module tb_spi_operand_loader;
  localparam int N  = 8;
  localparam int SS = 2;
  localparam int H  = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic         spi_miso, op_valid, frame_err;
  logic         op_ready = 1'b0;
  logic [N-1:0] op_a, op_b, res_sum;
  logic         res_cout;

  always #5 clk = ~clk;

  // Downstream adder.
  assign {res_cout, res_sum} = {1'b0, op_a} + {1'b0, op_b};

  spi_operand_loader #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_ready(op_ready), .res_sum(res_sum),
    .res_cout(res_cout), .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;

  logic [2*N-1:0] exp_ops[$];
  bit             exp_err[$];
  logic [2*N-1:0] miso_exp[$];
  logic [2*N-1:0] miso_got[$];
  logic [N:0]     model_res = '0;
  bit             pending = 1'b0;
  int             ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    exp_ops.delete();
    exp_err.delete();
    miso_exp.delete();
    miso_got.delete();
    pending   = 1'b0;
    model_res = '0;
  endtask

  // op_ready driver: 0 = held low, 1 = random, 2 = held high.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       op_ready = 1'b0;
      1:       op_ready = 1'($urandom_range(0, 1));
      default: op_ready = 1'b1;
    endcase
  end

  // Monitor: operand handshakes, frame_err pulses and completed MISO words.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (op_valid) begin
        if (exp_ops.size() == 0) begin
          check("spurious_op_valid", 32'(op_valid), 32'd0);
        end else begin
          check("op_a", 32'(op_a), 32'(exp_ops[0][2*N-1:N]));
          check("op_b", 32'(op_b), 32'(exp_ops[0][N-1:0]));
          if (op_ready) begin
            model_res = {1'b0, exp_ops[0][2*N-1:N]} + {1'b0, exp_ops[0][N-1:0]};
            $display("[TB] handshake a=%02h b=%02h result=%03h", exp_ops[0][2*N-1:N],
                     exp_ops[0][N-1:0], model_res);
            void'(exp_ops.pop_front());
            pending = 1'b0;
          end
        end
      end
      if (frame_err) begin
        check("frame_err_expected", 32'(exp_err.size() > 0), 32'd1);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
      if (miso_got.size() > 0 && miso_exp.size() > 0) begin
        check("miso_word", 32'(miso_got[0]), 32'(miso_exp[0]));
        void'(miso_got.pop_front());
        void'(miso_exp.pop_front());
      end
    end
  end

  // SPI mode-0 master; rst_at >= 0 pulses rst_n before that bit and ends the frame.
  task automatic send_frame(input logic [2*N-1:0] data, input int nbits, input int rst_at,
                            output logic [2*N-1:0] got);
    got = '0;
    spi_mosi = data[2*N-1];
    @(posedge clk);
    #2;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        break;
      end
      spi_mosi = (i < 2*N) ? data[2*N-1-i] : 1'($urandom_range(0, 1));
      tick(H);
      if (i < 2*N) got[2*N-1-i] = spi_miso;
      spi_sclk = 1'b1;
      tick(H);
      spi_sclk = 1'b0;
    end
    tick(H);
    spi_cs_n = 1'b1;
  endtask

  task automatic frame_txn(input logic [2*N-1:0] data, input int nbits);
    logic [2*N-1:0] got, exp_w;
    string kind;
    int saved;
    saved = ready_mode;
    if (pending) begin
      ready_mode = 0;
      tick(2);
    end
    exp_w = pending ? '0 : {model_res, {(N-1){1'b0}}};
    if (pending) begin
      exp_err.push_back(1'b1);
      kind = "rejected";
    end else if (nbits == 0) begin
      kind = "empty";
    end else if (nbits < 2*N) begin
      exp_err.push_back(1'b1);
      kind = "aborted";
    end else begin
      exp_ops.push_back(data);
      pending = 1'b1;
      kind = "accepted";
    end
    send_frame(data, nbits, -1, got);
    ready_mode = saved;
    if (nbits >= 2*N) begin
      miso_exp.push_back(exp_w);
      miso_got.push_back(got);
    end
    $display("[TB] frame %s bits=%0d data=%04h miso=%04h expect_miso=%04h", kind, nbits,
             data, got, exp_w);
    tick(10);
    check("frame_err_missing", 32'(exp_err.size()), 32'd0);
    exp_err.delete();
    if (ready_mode != 0 && pending) begin
      for (int k = 0; k < 300 && pending; k++) @(posedge clk);
      #2;
      check("handshake_timeout", 32'(pending), 32'd0);
      if (pending) begin
        exp_ops.delete();
        pending = 1'b0;
      end
    end
  endtask

  initial begin
    logic [2*N-1:0] d, got;
    int r, nb;

    // Reset state, then quiet idle after release.
    tick(3);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(20);
    check("idle_outputs", 32'({op_a, op_b, op_valid, spi_miso, frame_err}), 32'd0);

    // Basic frame, then its result on MISO.
    ready_mode = 2;
    frame_txn(16'h3C5A, 2*N);
    check("ops_kept_a", 32'(op_a), 32'h3C);
    check("ops_kept_b", 32'(op_b), 32'h5A);
    frame_txn(16'h0102, 2*N);

    // Carry-out result.
    frame_txn(16'hFF01, 2*N);
    frame_txn(16'h0000, 2*N);

    // Abort after 5 bits, then a clean frame.
    frame_txn(16'hFFFF, 5);
    check("abort_no_valid", 32'(op_valid), 32'd0);
    frame_txn(16'h1234, 2*N);

    // Backpressure with a rejected frame during the hold.
    ready_mode = 0;
    frame_txn(16'hC3E7, 2*N);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(op_valid), 32'd1);
    end
    frame_txn(16'h5555, 2*N);
    check("bp_still_valid", 32'(op_valid), 32'd1);
    ready_mode = 2;
    tick(2);
    check("bp_handshake_1cyc", 32'(pending), 32'd0);
    check("bp_valid_dropped", 32'(op_valid), 32'd0);
    check("bp_ops_kept", 32'({op_a, op_b}), 32'hC3E7);

    // Asynchronous reset asserted mid-cycle while op_valid is high.
    ready_mode = 0;
    frame_txn(16'h7E81, 2*N);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(op_valid), 32'd0);
    check("async_rst_ops", 32'({op_a, op_b}), 32'd0);
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // Reset in the middle of a frame.
    send_frame(16'hFFFF, 2*N, 7, got);
    model_reset();
    tick(10);
    check("midframe_rst_clear", 32'({op_valid, frame_err}), 32'd0);
    ready_mode = 2;
    frame_txn(16'hA50F, 2*N);

    // Randomized frames with random backpressure.
    for (int t = 0; t < 40; t++) begin
      ready_mode = int'($urandom_range(0, 1));
      d = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      nb = 0;
      else if (r <= 2) nb = int'($urandom_range(1, 2*N-1));
      else if (r <= 7) nb = 2*N;
      else             nb = 2*N + int'($urandom_range(1, 5));
      frame_txn(d, nb);
    end

    ready_mode = 2;
    for (int k = 0; k < 50 && pending; k++) @(posedge clk);
    tick(5);
    check("final_drain", 32'(exp_ops.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
